// File: rtl/regfile_sync_responder.sv
// regfile_sync_responder: 32-entry handshaked register file with post-reset clear sweep and registered, forwarding read ports
//   Clk, Reset                         clock (posedge), asynchronous active-high reset
//   WriteData, WriteRegister, RegWrite write port; writes to register 0 are dropped
//   ReadRegister1/2, ReadEnable        read request for both ports
//   ReadData1/2, ReadValid             registered read data and its one-cycle valid pulse
//   Ready                              requests are accepted at the next posedge
module regfile_sync_responder #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic [ADDR_WIDTH-1:0] WriteRegister,
    input  logic                  RegWrite,
    input  logic [ADDR_WIDTH-1:0] ReadRegister1,
    input  logic [ADDR_WIDTH-1:0] ReadRegister2,
    input  logic                  ReadEnable,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2,
    output logic                  ReadValid,
    output logic                  Ready
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST = '1;
    typedef enum logic {CLEAR, RUN} state_t;
    localparam state_t INIT = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
    state_t state, state_nx;
    logic [ADDR_WIDTH-1:0] clear_ptr, clear_ptr_nx;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic wr_en, rd_en;
    logic [DATA_WIDTH-1:0] rd1_nx, rd2_nx;
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= INIT;
            clear_ptr <= ADDR_WIDTH'(1);
        end else begin
            state     <= state_nx;
            clear_ptr <= clear_ptr_nx;
        end
    end
    always_comb begin
        state_nx     = (state == CLEAR && clear_ptr == LAST) ? RUN : state;
        clear_ptr_nx = (state == CLEAR) ? clear_ptr + ADDR_WIDTH'(1) : clear_ptr;
    end
    // Ready is low throughout CLEAR, so it alone gates request acceptance.
    assign wr_en = Ready && RegWrite && (WriteRegister != '0);
    assign rd_en = Ready && ReadEnable;
    // Same-edge write is forwarded so a read sees the value being written.
    always_comb begin
        rd1_nx = (ReadRegister1 == '0) ? '0 :
                 (wr_en && ReadRegister1 == WriteRegister) ? WriteData : mem[ReadRegister1];
        rd2_nx = (ReadRegister2 == '0) ? '0 :
                 (wr_en && ReadRegister2 == WriteRegister) ? WriteData : mem[ReadRegister2];
    end
    // Storage has no reset; edges seen while Reset is held must not write.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            if (state == CLEAR)
                mem[clear_ptr] <= '0;
            else if (wr_en)
                mem[WriteRegister] <= WriteData;
        end
    end
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Ready     <= 1'b0;
            ReadValid <= 1'b0;
            ReadData1 <= '0;
            ReadData2 <= '0;
        end else begin
            Ready     <= (state_nx == RUN);
            ReadValid <= rd_en;
            if (rd_en) begin
                ReadData1 <= rd1_nx;
                ReadData2 <= rd2_nx;
            end
        end
    end
endmodule

// File: tb/tb_regfile_sync_responder.sv
// tb_regfile_sync_responder: table, directed and random checks of regfile_sync_responder against an array model
module tb_regfile_sync_responder;
    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [31:0] WriteData = '0;
    logic [4:0]  WriteRegister = '0;
    logic        RegWrite = 1'b0;
    logic [4:0]  ReadRegister1 = '0;
    logic [4:0]  ReadRegister2 = '0;
    logic        ReadEnable = 1'b0;
    logic [31:0] ReadData1, ReadData2;
    logic        ReadValid, Ready;
    regfile_sync_responder dut (
        .Clk(Clk), .Reset(Reset),
        .WriteData(WriteData), .WriteRegister(WriteRegister), .RegWrite(RegWrite),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2), .ReadEnable(ReadEnable),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .ReadValid(ReadValid), .Ready(Ready)
    );
    always #5 Clk = ~Clk;
    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        re;
        logic [4:0]  ra1, ra2;
        logic        ev;
        logic [31:0] e1, e2;
    } vec_t;
    vec_t vecs[$];
    int total = 0;
    int passed = 0;
    logic [31:0] m [32];
    logic [31:0] e1, e2;
    logic        ev;
    logic        ready_m;
    int          clear_cnt;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else passed++;
    endtask
    task automatic model_reset();
        ev = 1'b0; e1 = '0; e2 = '0; ready_m = 1'b0; clear_cnt = 0;
        foreach (m[i]) m[i] = '0;
    endtask
    // One clock: the model applies the write first, so reads naturally see it.
    task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic re, input logic [4:0] ra1, input logic [4:0] ra2);
        RegWrite = we; WriteRegister = wa; WriteData = wd;
        ReadEnable = re; ReadRegister1 = ra1; ReadRegister2 = ra2;
        @(posedge Clk);
        if (ready_m) begin
            if (we && wa != 5'd0) m[wa] = wd;
            ev = re;
            if (re) begin
                e1 = m[ra1];
                e2 = m[ra2];
            end
        end else begin
            ev = 1'b0;
            clear_cnt++;
            if (clear_cnt == 31) ready_m = 1'b1;
        end
        #1;
        check("ready", 32'(Ready), 32'(ready_m));
        check("valid", 32'(ReadValid), 32'(ev));
        check("rd1", ReadData1, e1);
        check("rd2", ReadData2, e2);
    endtask
    task automatic add(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic re, input logic [4:0] ra1, input logic [4:0] ra2,
                       input logic xv, input logic [31:0] x1, input logic [31:0] x2);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra1 = ra1; v.ra2 = ra2;
        v.ev = xv; v.e1 = x1; v.e2 = x2;
        vecs.push_back(v);
    endtask
    initial begin
        model_reset();
        #1 Reset = 1'b1;
        #1;
        check("rst_ready", 32'(Ready), 32'd0);
        check("rst_valid", 32'(ReadValid), 32'd0);
        check("rst_rd1", ReadData1, 32'd0);
        check("rst_rd2", ReadData2, 32'd0);
        #1 Reset = 1'b0;
        for (int i = 0; i < 31; i++) step(1'b1, 5'd2, 32'd42, 1'b1, 5'd2, 5'd2);
        check("sweep_done_ready", 32'(Ready), 32'd1);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 5'd2);
        check("post_sweep_r2", ReadData1, 32'd0);
        add(1'b1, 5'd2, 32'd15,         1'b0, 5'd0, 5'd0, 1'b0, 32'd0,         32'd0);
        add(1'b0, 5'd0, 32'd0,          1'b1, 5'd2, 5'd3, 1'b1, 32'd15,        32'd0);
        add(1'b0, 5'd0, 32'd0,          1'b0, 5'd7, 5'd7, 1'b0, 32'd15,        32'd0);
        add(1'b1, 5'd6, 32'hDEADBEEF,   1'b1, 5'd6, 5'd6, 1'b1, 32'hDEADBEEF,  32'hDEADBEEF);
        add(1'b1, 5'd0, 32'd15,         1'b1, 5'd0, 5'd0, 1'b1, 32'd0,         32'd0);
        add(1'b0, 5'd0, 32'd0,          1'b1, 5'd0, 5'd0, 1'b1, 32'd0,         32'd0);
        add(1'b1, 5'd2, 32'd0,          1'b0, 5'd0, 5'd0, 1'b0, 32'd0,         32'd0);
        add(1'b0, 5'd2, 32'd42,         1'b0, 5'd0, 5'd0, 1'b0, 32'd0,         32'd0);
        add(1'b0, 5'd0, 32'd0,          1'b1, 5'd2, 5'd6, 1'b1, 32'd0,         32'hDEADBEEF);
        add(1'b0, 5'd0, 32'd0,          1'b0, 5'd1, 5'd1, 1'b0, 32'd0,         32'hDEADBEEF);
        add(1'b0, 5'd0, 32'd0,          1'b1, 5'd6, 5'd2, 1'b1, 32'hDEADBEEF,  32'd0);
        add(1'b0, 5'd0, 32'd0,          1'b1, 5'd2, 5'd6, 1'b1, 32'd0,         32'hDEADBEEF);
        foreach (vecs[i]) begin
            step(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra1, vecs[i].ra2);
            check($sformatf("vec%0d_valid", i), 32'(ReadValid), 32'(vecs[i].ev));
            check($sformatf("vec%0d_rd1", i), ReadData1, vecs[i].e1);
            check($sformatf("vec%0d_rd2", i), ReadData2, vecs[i].e2);
        end
        for (int i = 0; i < 300; i++) begin
            logic [4:0] wa, ra1, ra2;
            wa  = 5'(($urandom & 1) != 0 ? $urandom_range(0, 3) : $urandom_range(0, 31));
            ra1 = 5'(($urandom & 1) != 0 ? $urandom_range(0, 3) : $urandom_range(0, 31));
            ra2 = 5'(($urandom & 1) != 0 ? $urandom_range(0, 3) : $urandom_range(0, 31));
            step(1'($urandom_range(0, 1)), wa, $urandom, 1'($urandom_range(0, 1)), ra1, ra2);
        end
        step(1'b1, 5'd9, 32'd7, 1'b0, 5'd0, 5'd0);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9);
        check("pre_reset_r9", ReadData1, 32'd7);
        RegWrite = 1'b0; ReadEnable = 1'b0;
        #1 Reset = 1'b1;
        #1;
        check("midrst_ready", 32'(Ready), 32'd0);
        check("midrst_valid", 32'(ReadValid), 32'd0);
        check("midrst_rd1", ReadData1, 32'd0);
        check("midrst_rd2", ReadData2, 32'd0);
        #2 Reset = 1'b0;
        model_reset();
        for (int i = 0; i < 31; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9);
        check("post_reset_r9_rd1", ReadData1, 32'd0);
        check("post_reset_r9_rd2", ReadData2, 32'd0);
        check("post_reset_r9_valid", 32'(ReadValid), 32'd1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/regfile_sync_responder.md
# regfile_sync_responder

Synchronous, handshaked 32-entry register file. It is the responder for the register-file driver interface (WriteData/WriteRegister/RegWrite, ReadRegister1/ReadRegister2 -> ReadData1/ReadData2). It adds three things to that interface:
- a hardware clear sweep after reset;
- registered read ports with one-cycle latency and same-cycle write forwarding;
- a Ready/ReadValid handshake.

It sits between the CPU decode stage and the execute-stage operand registers.

## Interface
- DATA_WIDTH, 32, register data width.
- ADDR_WIDTH, 5, register address width; depth = 2^ADDR_WIDTH.
- CLEAR_ON_RESET, 1, 1 = sweep registers 1..depth-1 to zero after reset; 0 = no sweep, contents undefined until written.

Ports:
- Clk  input  1  clock, posedge active.
- Reset  input  1  asynchronous, active-high reset.
- WriteData  input  DATA_WIDTH  data to write.
- WriteRegister  input  ADDR_WIDTH  write address.
- RegWrite  input  1  write request, sampled at posedge.
- ReadRegister1  input  ADDR_WIDTH  read port 1 address.
- ReadRegister2  input  ADDR_WIDTH  read port 2 address.
- ReadEnable  input  1  read request for both ports, sampled at posedge.
- ReadData1  output  DATA_WIDTH  registered read data, port 1.
- ReadData2  output  DATA_WIDTH  registered read data, port 2.
- ReadValid  output  1  one-cycle pulse, ReadData1/2 updated by an accepted read.
- Ready  output  1  block accepts RegWrite/ReadEnable at the next posedge.

## Operation
- There is one clock domain. Reset is asynchronous and active-high.
- While Reset is high, all outputs are held at:
  - Ready=0, ReadValid=0;
  - ReadData1=0, ReadData2=0;
  - state = CLEAR (or RUN if CLEAR_ON_RESET=0);
  - ClearPtr=1.
- The storage array is not asynchronously reset.
- State CLEAR:
  - Each posedge writes 0 to register ClearPtr, then ClearPtr increments.
  - On the edge that writes register depth-1, the state goes to RUN and Ready goes to 1.
  - RegWrite and ReadEnable are ignored: nothing is written and ReadValid stays 0.
- State RUN, Ready=1 permanently until the next Reset.
- Write:
  - RegWrite=1 at a posedge stores WriteData into WriteRegister.
  - A write to register 0 is discarded.
- Read:
  - ReadEnable=1 at a posedge loads ReadData1/2 from ReadRegister1/2.
  - ReadValid=1 in the following cycle.
  - With ReadEnable=0, ReadData1/2 hold their last values and ReadValid=0.
- Register 0 always reads 0 on both ports.
- Forwarding: if RegWrite and ReadEnable are accepted on the same edge and a read address equals a nonzero WriteRegister, that port returns the new WriteData, not the old contents.
- Both ports may address the same register; both return identical data.
- Reset asserted mid-operation:
  - outputs go to their reset values immediately (combinationally from Reset);
  - an in-flight read is dropped (no ReadValid);
  - the sweep restarts from register 1 after release.
- Register contents written before a mid-operation reset are destroyed by the sweep when CLEAR_ON_RESET=1, and retained when CLEAR_ON_RESET=0.

## Timing
- Reset released before posedge 1: posedges 1..31 clear registers 1..31, and Ready=1 after posedge 31.
- The first accepted request is at posedge 32. Clear duration is 2^ADDR_WIDTH-1 cycles.
- With CLEAR_ON_RESET=0, Ready=1 after posedge 1, and the first accepted request is at posedge 2.
- Write latency is one edge: a read accepted on the edge after a write returns the written value.
- Read latency is one cycle: data and ReadValid are valid after the accepting posedge, until the next posedge.
- Back-to-back reads on consecutive edges give ReadValid high continuously, with data updating each cycle.
- Ready, ReadValid, ReadData1 and ReadData2 are all registered outputs with no combinational path from inputs, except the asynchronous Reset.

## Test plan
- Reset, then RegWrite=1 with WriteRegister=2, WriteData=42 and ReadEnable=1 each cycle during the clear sweep -> Ready=0 for 31 cycles and ReadValid never 1. After Ready=1, reading register 2 -> ReadData1=ReadData2=0 and ReadValid=1.
- RUN state: write 15 to register 2, then read ReadRegister1=2, ReadRegister2=3 on the next edge -> ReadData1=15, ReadData2=0, ReadValid=1 for exactly one cycle.
- Same edge: RegWrite=1 to register 6 with WriteData=0xDEADBEEF, and ReadEnable=1 with ReadRegister1=ReadRegister2=6 -> both ports return 0xDEADBEEF next cycle (forwarding).
- Write 15 to register 0, with a same-edge read of register 0, then a second read of register 0 -> both reads return 0 on both ports.
- Write 0 to register 2, then present WriteData=42 with RegWrite=0, then read register 2 -> 0. With ReadEnable=0, ReadData holds its value and ReadValid=0.
- Write 7 to register 9, then assert Reset for 3 ns in the middle of a cycle that has a read in flight -> ReadValid=0 and ReadData=0 immediately, Ready=0 for 31 cycles, and register 9 then reads 0 (CLEAR_ON_RESET=1).
